// File: rtl/bsk_prm_sequencer_if.sv
// bsk_prm_sequencer_if: register bus between the sequencer and the BSK PRM chip.
//  oCS   chip address (CS during an access, CS_IDLE otherwise)
//  oA    register address
//  oWr   write strobe, active low
//  oRd   read strobe, active low
//  oD    write data
//  oDOe  1 = master drives oD onto the shared bus
//  iD    read data returned by the chip
//  master modport: sequencer side; slave modport: chip side.
interface bsk_prm_sequencer_if;
    logic [3:0]  oCS;
    logic [1:0]  oA;
    logic        oWr;
    logic        oRd;
    logic [15:0] oD;
    logic        oDOe;
    logic [15:0] iD;
    modport master (output oCS, oA, oWr, oRd, oD, oDOe, input iD);
    modport slave (input oCS, oA, oWr, oRd, oD, oDOe, output iD);
endinterface

// File: rtl/bsk_prm_sequencer.sv
// bsk_prm_sequencer: clocked bus master that loads a BSK PRM command-output chip.
//  Writes the command words (nibble + complement pairs), the indication word and the
//  terminal-enable code, then optionally reads addresses 1 and 3 back and checks them.
//  Optional feature macro: BSK_PRM_SEQ_READBACK_EN (defined = readback steps R1/R3 run).
//  Ports:
//   iClk      system clock
//   iRes      asynchronous reset, active low
//   iStart    load request pulse, honoured only in IDLE
//   iCom      commands to load
//   iInd      indication word
//   iEn       1 = write ENABLE code, 0 = write 8'h00
//   oBusy     sequence in progress
//   oDone     1-cycle pulse at end of sequence
//   oErrCom   readback of address 1 differs from latched iCom (sticky until next start)
//   oErrPass  readback of address 3 has wrong password or wrong enable bit (sticky)
//   bus       chip register bus (master modport)
module bsk_prm_sequencer #(
    parameter logic [3:0] CS        = 4'b0111,
    parameter logic [3:0] CS_IDLE   = 4'b1111,
    parameter logic [7:0] PASSWORD  = 8'hA6,
    parameter logic [7:0] ENABLE    = 8'hE1,
    parameter int         SETUP_CYC = 1,
    parameter int         STB_CYC   = 2
) (
    input  logic                iClk,
    input  logic                iRes,
    input  logic                iStart,
    input  logic [15:0]         iCom,
    input  logic [15:0]         iInd,
    input  logic                iEn,
    output logic                oBusy,
    output logic                oDone,
    output logic                oErrCom,
    output logic                oErrPass,
    bsk_prm_sequencer_if.master bus
);
`ifdef BSK_PRM_SEQ_READBACK_EN
    localparam logic       RB   = 1'b1;
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic       RB   = 1'b0;
    localparam logic [2:0] LAST = 3'd3;
`endif
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STB_LD   = 4'(STB_CYC - 1);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_step;
    logic [15:0] r_com;
    logic [15:0] r_ind;
    logic        r_en;
    logic [15:0] w_com;
    logic [15:0] w_ind;
    logic        w_en;
    logic [2:0]  w_nstep;
    logic        w_nwr;
    logic        w_cur_wr;
    logic [1:0]  w_naddr;
    logic [15:0] w_ndata;
    logic        w_load;
    // Step 0 is set up on the same edge that latches the request, so it must see the raw inputs.
    always_comb begin
        w_com    = (r_state == IDLE) ? iCom : r_com;
        w_ind    = (r_state == IDLE) ? iInd : r_ind;
        w_en     = (r_state == IDLE) ? iEn : r_en;
        w_nstep  = (r_state == IDLE) ? 3'd0 : r_step + 3'd1;
        w_nwr    = w_nstep < 3'd4;
        w_cur_wr = !RB || r_step < 3'd4;
        w_naddr  = (w_nstep == 3'd4) ? 2'd1 : (w_nstep == 3'd5) ? 2'd3 : w_nstep[1:0];
        w_ndata  = (w_nstep == 3'd0) ? {w_com[7:4], ~w_com[7:4], w_com[3:0], ~w_com[3:0]} :
                   (w_nstep == 3'd1) ? {w_com[15:12], ~w_com[15:12], w_com[11:8], ~w_com[11:8]} :
                   (w_nstep == 3'd2) ? w_ind :
                   (w_nstep == 3'd3) ? {8'h00, w_en ? ENABLE : 8'h00} : 16'h0000;
        w_load   = (r_state == IDLE && iStart) || (r_state == HOLD && r_step != LAST);
    end
    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_step   <= 3'd0;
            r_com    <= 16'h0000;
            r_ind    <= 16'h0000;
            r_en     <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oErrCom  <= 1'b0;
            oErrPass <= 1'b0;
            bus.oCS  <= CS_IDLE;
            bus.oA   <= 2'd0;
            bus.oWr  <= 1'b1;
            bus.oRd  <= 1'b1;
            bus.oD   <= 16'h0000;
            bus.oDOe <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (r_state)
                IDLE: if (iStart) begin
                    r_com    <= iCom;
                    r_ind    <= iInd;
                    r_en     <= iEn;
                    oErrCom  <= 1'b0;
                    oErrPass <= 1'b0;
                    oBusy    <= 1'b1;
                end
                SETUP: if (r_cnt == 4'd0) begin
                    r_state <= STROBE;
                    r_cnt   <= STB_LD;
                    bus.oWr <= !w_cur_wr;
                    bus.oRd <= w_cur_wr;
                end else r_cnt <= r_cnt - 4'd1;
                STROBE: if (r_cnt == 4'd0) begin
                    r_state <= HOLD;
                    bus.oWr <= 1'b1;
                    bus.oRd <= 1'b1;
                    // Read data is taken on the edge that ends the strobe.
                    if (!w_cur_wr && bus.oA == 2'd1 && bus.iD != r_com) oErrCom <= 1'b1;
                    if (!w_cur_wr && bus.oA == 2'd3 && (bus.iD[15:8] != PASSWORD || bus.iD[0] == r_en))
                        oErrPass <= 1'b1;
                end else r_cnt <= r_cnt - 4'd1;
                HOLD: if (r_step == LAST) begin
                    r_state  <= DONE;
                    oBusy    <= 1'b0;
                    oDone    <= 1'b1;
                    bus.oCS  <= CS_IDLE;
                    bus.oDOe <= 1'b0;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_load) begin
                r_state  <= SETUP;
                r_cnt    <= SETUP_LD;
                r_step   <= w_nstep;
                bus.oCS  <= CS;
                bus.oA   <= w_naddr;
                bus.oD   <= w_ndata;
                bus.oDOe <= w_nwr;
            end
        end
    end
endmodule

// File: tb/tb_bsk_prm_sequencer.sv
// tb_bsk_prm_sequencer: random and directed load sequences checked every cycle against a timeline model.
module tb_bsk_prm_sequencer;
`ifdef BSK_PRM_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int N = RB ? 6 : 4;
    logic        clk, res, st, en;
    logic [15:0] com, ind, rb1, rb3;
    int          n_tests = 0, n_fail = 0;
    logic        o_busy[2], o_done[2], o_ec[2], o_ep[2], o_wr[2], o_rd[2], o_doe[2];
    logic [3:0]  o_cs[2];
    logic [1:0]  o_a[2];
    logic [15:0] o_d[2];
    int          m_k[2];
    logic [15:0] m_com[2], m_ind[2];
    logic        m_en[2], m_ec[2], m_ep[2];
    logic [15:0] wr_log[4];
    bsk_prm_sequencer_if bus0();
    bsk_prm_sequencer_if bus1();
    bsk_prm_sequencer u0 (.iClk(clk), .iRes(res), .iStart(st), .iCom(com), .iInd(ind), .iEn(en),
        .oBusy(o_busy[0]), .oDone(o_done[0]), .oErrCom(o_ec[0]), .oErrPass(o_ep[0]), .bus(bus0));
    bsk_prm_sequencer #(.SETUP_CYC(3), .STB_CYC(1)) u1 (.iClk(clk), .iRes(res), .iStart(st), .iCom(com),
        .iInd(ind), .iEn(en), .oBusy(o_busy[1]), .oDone(o_done[1]), .oErrCom(o_ec[1]), .oErrPass(o_ep[1]),
        .bus(bus1));
    assign bus0.iD = !bus0.oRd ? (bus0.oA == 2'd1 ? rb1 : rb3) : 16'h0000;
    assign bus1.iD = !bus1.oRd ? (bus1.oA == 2'd1 ? rb1 : rb3) : 16'h0000;
    assign o_cs[0] = bus0.oCS; assign o_a[0] = bus0.oA; assign o_wr[0] = bus0.oWr;
    assign o_rd[0] = bus0.oRd; assign o_d[0] = bus0.oD; assign o_doe[0] = bus0.oDOe;
    assign o_cs[1] = bus1.oCS; assign o_a[1] = bus1.oA; assign o_wr[1] = bus1.oWr;
    assign o_rd[1] = bus1.oRd; assign o_d[1] = bus1.oD; assign o_doe[1] = bus1.oDOe;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input int u, input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s t=%0t got=%h want=%h", u, nm, $time, act, exp);
        end
    endtask
    function automatic logic [15:0] m_data(int idx, logic [15:0] c, logic [15:0] i, logic e);
        return idx == 0 ? {c[7:4], ~c[7:4], c[3:0], ~c[3:0]} :
               idx == 1 ? {c[15:12], ~c[15:12], c[11:8], ~c[11:8]} :
               idx == 2 ? i : {8'h00, e ? 8'hE1 : 8'h00};
    endfunction
    function automatic logic [1:0] m_addr(int idx);
        return idx == 4 ? 2'd1 : idx == 5 ? 2'd3 : 2'(idx);
    endfunction
    // Model: m_k = cycles since the accepting edge (0 = idle); accesses of length l laid end to end.
    always @(posedge clk or negedge res) begin
        int l;
        if (!res) begin
            for (int i = 0; i < 2; i++) begin m_k[i] = 0; m_ec[i] = 0; m_ep[i] = 0; end
        end else for (int i = 0; i < 2; i++) begin
            l = i ? 5 : 4;
            if (m_k[i] == 0) begin
                if (st) begin
                    m_k[i] = 1; m_com[i] = com; m_ind[i] = ind; m_en[i] = en; m_ec[i] = 0; m_ep[i] = 0;
                end
            end else m_k[i] = (m_k[i] == N * l + 1) ? 0 : m_k[i] + 1;
            if (RB && m_k[i] == 5 * l && rb1 != m_com[i]) m_ec[i] = 1;
            if (RB && m_k[i] == 6 * l && (rb3[15:8] != 8'hA6 || rb3[0] != !m_en[i])) m_ep[i] = 1;
        end
    end
    always @(negedge clk) if (res) begin
        int s, b, l, k, idx, p;
        logic stb;
        for (int i = 0; i < 2; i++) begin
            s = i ? 3 : 1; b = i ? 1 : 2; l = s + b + 1; k = m_k[i];
            chk(i, "errcom", o_ec[i], m_ec[i]);
            chk(i, "errpass", o_ep[i], m_ep[i]);
            if (k == 0 || k == N * l + 1) begin
                chk(i, "busy", o_busy[i], 0);
                chk(i, "done", o_done[i], k != 0);
                chk(i, "wr", o_wr[i], 1);
                chk(i, "rd", o_rd[i], 1);
                if (k == 0) chk(i, "cs_idle", o_cs[i], 4'hF);
            end else begin
                idx = (k - 1) / l; p = (k - 1) % l; stb = p >= s && p < s + b;
                chk(i, "busy", o_busy[i], 1);
                chk(i, "done", o_done[i], 0);
                chk(i, "cs", o_cs[i], 4'h7);
                chk(i, "addr", o_a[i], m_addr(idx));
                chk(i, "wr", o_wr[i], !(stb && idx < 4));
                chk(i, "rd", o_rd[i], !(stb && idx >= 4));
                chk(i, "doe", o_doe[i], idx < 4);
                if (idx < 4) chk(i, "data", o_d[i], m_data(idx, m_com[i], m_ind[i], m_en[i]));
            end
        end
    end
    always @(negedge clk) begin
        if (st && m_k[0] == 0) for (int j = 0; j < 4; j++) wr_log[j] = 16'hDEAD;
        else if (res && !o_wr[0]) wr_log[o_a[0]] = o_d[0];
    end
    task automatic run(input logic [15:0] c, input logic [15:0] i, input logic e, input logic [15:0] r1,
                       input logic [15:0] r3, input int g, output int done_at, output int ndone);
        @(posedge clk); #1;
        com = c; ind = i; en = e; rb1 = r1; rb3 = r3; st = 1; done_at = 0; ndone = 0;
        @(posedge clk); #1 st = 0;
        for (int cyc = 1; cyc <= N * 5 + 3; cyc++) begin
            @(negedge clk);
            if (o_done[0]) begin ndone++; if (done_at == 0) done_at = cyc; end
            if (cyc == g) begin #1 st = 1; com = 16'h0000; end
            if (cyc == g + 1) begin #1 st = 0; end
        end
    endtask
    initial begin
        int da, nd;
        logic [15:0] c, i;
        logic e;
        res = 0; st = 0; com = 0; ind = 0; en = 0; rb1 = 0; rb3 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "rst_wr", o_wr[0], 1); chk(0, "rst_rd", o_rd[0], 1);
        chk(0, "rst_cs", o_cs[0], 4'hF); chk(0, "rst_a", o_a[0], 0);
        chk(0, "rst_d", o_d[0], 0); chk(0, "rst_doe", o_doe[0], 0);
        chk(0, "rst_busy", o_busy[0], 0); chk(0, "rst_done", o_done[0], 0);
        chk(0, "rst_ec", o_ec[0], 0); chk(0, "rst_ep", o_ep[0], 0);
        res = 1;
        run(16'h1234, 16'h00FF, 1, 16'h1234, 16'hA690, 0, da, nd);
        chk(0, "basic_a0", wr_log[0], 16'h3C4B); chk(0, "basic_a1", wr_log[1], 16'h1E2D);
        chk(0, "basic_a2", wr_log[2], 16'h00FF); chk(0, "basic_a3", wr_log[3], 16'h00E1);
        chk(0, "basic_done_cyc", 16'(da), RB ? 16'd25 : 16'd17);
        chk(0, "basic_ndone", 16'(nd), 1);
        run(16'hFFFF, 16'h5A5A, 0, 16'hFFFF, 16'hA691, 0, da, nd);
        chk(0, "dis_a0", wr_log[0], 16'hF0F0); chk(0, "dis_a1", wr_log[1], 16'hF0F0);
        chk(0, "dis_a3", wr_log[3], 16'h0000);
        run(16'h1234, 16'h00FF, 1, 16'h1234, 16'hA690, 9, da, nd);
        chk(0, "guard_a0", wr_log[0], 16'h3C4B); chk(0, "guard_ndone", 16'(nd), 1);
`ifdef BSK_PRM_SEQ_READBACK_EN
        run(16'h1234, 16'h0000, 0, 16'h1234, 16'hA691, 0, da, nd);
        chk(0, "rb_ok_ec", o_ec[0], 0); chk(0, "rb_ok_ep", o_ep[0], 0);
        run(16'h1234, 16'h0000, 0, 16'h1235, 16'hA691, 0, da, nd);
        chk(0, "rb_com_ec", o_ec[0], 1); chk(0, "rb_com_ep", o_ep[0], 0);
        run(16'h1234, 16'h0000, 0, 16'h1234, 16'hA590, 0, da, nd);
        chk(0, "rb_pass_ec", o_ec[0], 0); chk(0, "rb_pass_ep", o_ep[0], 1);
`endif
        @(posedge clk); #1;
        com = 16'h1234; ind = 0; en = 1; st = 1;
        @(posedge clk); #1 st = 0;
        repeat (6) @(negedge clk);
        chk(0, "mid_wr_low", o_wr[0], 0);
        #1 res = 0;
        #1;
        chk(0, "mid_wr_rel", o_wr[0], 1); chk(0, "mid_doe", o_doe[0], 0);
        chk(0, "mid_busy", o_busy[0], 0); chk(1, "mid_busy", o_busy[1], 0);
        @(posedge clk); #1 res = 1;
        nd = 0;
        repeat (40) begin @(negedge clk); if (o_done[0] || o_done[1]) nd++; end
        chk(0, "mid_nodone", 16'(nd), 0);
        for (int r = 0; r < 25; r++) begin
            c = 16'($urandom); i = 16'($urandom); e = 1'($urandom_range(0, 1));
            run(c, i, e, $urandom_range(0, 1) ? c : 16'($urandom),
                $urandom_range(0, 1) ? {8'hA6, 7'($urandom), !e} : 16'($urandom),
                $urandom_range(0, 1) ? $urandom_range(1, 16) : 0, da, nd);
            chk(0, "rand_ndone", 16'(nd), 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
